rope_ctrl: RTL and testbench

Game-logic stage directly upstream of the rope sprite generator: owns the rope's vertical position (`rope_loc`, a pixel row) for the tug-of-war display. Accumulates player pull pulses during each video frame, applies the net pull once per frame at the vsync rising edge, saturates the position to the playfield, and runs the round state machine that detects a winner. `rope_loc` feeds the sprite generator's row comparison directly.

---
 rtl/rope_ctrl.sv | 144 ++++++++++++++
 tb/tb_rope_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_ctrl.sv
// Tug-of-war rope position and round FSM, updated once per frame on vsync.
// Optional ROPE_DRIFT_EN: idle frames drift the rope one pixel toward CENTER.
module rope_ctrl #(
  parameter int CENTER       = 240,
  parameter int STEP         = 4,
  parameter int WIN_MARGIN   = 100,
  parameter int LOC_MIN      = 20,
  parameter int LOC_MAX      = 460,
  parameter int CNT_W        = 4,
  parameter int DRIFT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       pull_a,
  input  logic       pull_b,
  input  logic       start,
  output logic [9:0] rope_loc,
  output logic [1:0] game_state,
  output logic       frame_upd
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    WIN_A = 2'b10,
    WIN_B = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic signed [11:0] CTR  = 12'(CENTER);
  localparam logic signed [11:0] STP  = 12'(STEP);
  localparam logic signed [11:0] LMIN = 12'(LOC_MIN);
  localparam logic signed [11:0] LMAX = 12'(LOC_MAX);
  localparam logic signed [11:0] WLO  = 12'(CENTER - WIN_MARGIN);
  localparam logic signed [11:0] WHI  = 12'(CENTER + WIN_MARGIN);

  state_t           st, st_n;
  logic             vs_q, fe;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [9:0]       loc_n;
  logic             upd_n;
  logic signed [11:0] nv, fin;

`ifdef ROPE_DRIFT_EN
  localparam int DW = $clog2(DRIFT_FRAMES + 1);
  logic [DW-1:0] dcnt, dcnt_n;

  always_ff @(posedge clk) begin
    if (reset) dcnt <= '0;
    else       dcnt <= dcnt_n;
  end
`else
  logic unused_drift;
  assign unused_drift = ^32'(DRIFT_FRAMES);
`endif

  // Edge is registered so the update lands two edges after vsync rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q      <= 1'b0;
      fe        <= 1'b0;
      st        <= IDLE;
      rope_loc  <= 10'(CENTER);
      cnt_a     <= '0;
      cnt_b     <= '0;
      frame_upd <= 1'b0;
    end else begin
      vs_q      <= vsync;
      fe        <= vsync & ~vs_q;
      st        <= st_n;
      rope_loc  <= loc_n;
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      frame_upd <= upd_n;
    end
  end

  always_comb begin
    st_n    = st;
    loc_n   = rope_loc;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    upd_n   = 1'b0;
`ifdef ROPE_DRIFT_EN
    dcnt_n  = dcnt;
`endif
    nv = $signed({2'b00, rope_loc})
       + ($signed(12'(cnt_b)) - $signed(12'(cnt_a))) * STP;
    if (nv < LMIN)      fin = LMIN;
    else if (nv > LMAX) fin = LMAX;
    else                fin = nv;

    unique case (st)
      PLAY: begin
        if (start) begin
          loc_n   = 10'(CENTER);
          cnt_a_n = '0;
          cnt_b_n = '0;
`ifdef ROPE_DRIFT_EN
          dcnt_n  = '0;
`endif
        end else if (fe) begin
`ifdef ROPE_DRIFT_EN
          if (cnt_a == '0 && cnt_b == '0) begin
            if (dcnt == DW'(DRIFT_FRAMES - 1)) begin
              dcnt_n = '0;
              if (fin > CTR)      fin = fin - 12'sd1;
              else if (fin < CTR) fin = fin + 12'sd1;
            end else begin
              dcnt_n = dcnt + 1'b1;
            end
          end else begin
            dcnt_n = '0;
          end
`endif
          loc_n   = fin[9:0];
          upd_n   = 1'b1;
          cnt_a_n = CNT_W'(pull_a);
          cnt_b_n = CNT_W'(pull_b);
          if (fin <= WLO)      st_n = WIN_A;
          else if (fin >= WHI) st_n = WIN_B;
        end else begin
          if (pull_a && cnt_a != CMAX) cnt_a_n = cnt_a + 1'b1;
          if (pull_b && cnt_b != CMAX) cnt_b_n = cnt_b + 1'b1;
        end
      end
      default: begin
        if (start) begin
          st_n    = PLAY;
          loc_n   = 10'(CENTER);
          cnt_a_n = '0;
          cnt_b_n = '0;
`ifdef ROPE_DRIFT_EN
          dcnt_n  = '0;
`endif
        end
      end
    endcase
  end

  assign game_state = st;

endmodule

// File: tb/tb_rope_ctrl.sv
// Scoreboard bench for rope_ctrl: two instances (default and off-centre
// parameters) share stimulus and are checked against a frame-level model.
module tb_rope_ctrl;

  logic       clk = 1'b0;
  logic       reset, vsync, pull_a, pull_b, start;
  logic [9:0] loc0, loc1;
  logic [1:0] gs0, gs1;
  logic       upd0, upd1;
  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rope_ctrl u0 (
    .clk(clk), .reset(reset), .vsync(vsync), .pull_a(pull_a),
    .pull_b(pull_b), .start(start), .rope_loc(loc0),
    .game_state(gs0), .frame_upd(upd0)
  );

  rope_ctrl #(.CENTER(450), .WIN_MARGIN(200)) u1 (
    .clk(clk), .reset(reset), .vsync(vsync), .pull_a(pull_a),
    .pull_b(pull_b), .start(start), .rope_loc(loc1),
    .game_state(gs1), .frame_upd(upd1)
  );

  typedef struct {
    int loc;
    int st;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int mc[2]  = '{240, 450};
  int mw[2]  = '{100, 200};
  int m_loc[2], m_st[2], m_pa[2], m_pb[2], m_idle[2];

  function automatic void chk(string name, int act, int exp);
    total_cnt++;
    if (act != exp)
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_loc[i] = mc[i]; m_st[i] = 0;
      m_pa[i] = 0; m_pb[i] = 0; m_idle[i] = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  function automatic void m_start();
    for (int i = 0; i < 2; i++) begin
      m_loc[i] = mc[i]; m_st[i] = 1;
      m_pa[i] = 0; m_pb[i] = 0; m_idle[i] = 0;
    end
  endfunction

  function automatic void m_pull(int a, int b);
    for (int i = 0; i < 2; i++)
      if (m_st[i] == 1) begin
        m_pa[i] = (m_pa[i] + a > 15) ? 15 : m_pa[i] + a;
        m_pb[i] = (m_pb[i] + b > 15) ? 15 : m_pb[i] + b;
      end
  endfunction

  // Net pull applied at frame level; now = cycle on which vsync is raised.
  function automatic void m_frame(int now);
    exp_t e;
    int n;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] != 1) continue;
      n = m_loc[i] + (m_pb[i] - m_pa[i]) * 4;
      if (n < 20) n = 20;
      if (n > 460) n = 460;
`ifdef ROPE_DRIFT_EN
      if (m_pa[i] == 0 && m_pb[i] == 0) begin
        m_idle[i]++;
        if (m_idle[i] == 8) begin
          m_idle[i] = 0;
          if (n > mc[i]) n--;
          else if (n < mc[i]) n++;
        end
      end else begin
        m_idle[i] = 0;
      end
`endif
      if (n <= mc[i] - mw[i]) m_st[i] = 2;
      else if (n >= mc[i] + mw[i]) m_st[i] = 3;
      m_loc[i] = n;
      m_pa[i] = 0;
      m_pb[i] = 0;
      e.loc = n; e.st = m_st[i]; e.cyc = now + 2;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && upd0) begin
      chk("u0 upd expected", int'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("u0 upd loc", int'(loc0), e.loc);
        chk("u0 upd state", int'(gs0), e.st);
        chk("u0 upd cycle", cyc, e.cyc);
      end
    end
    if (!reset && upd1) begin
      chk("u1 upd expected", int'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("u1 upd loc", int'(loc1), e.loc);
        chk("u1 upd state", int'(gs1), e.st);
        chk("u1 upd cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit a, input bit b);
    pull_a = a;
    pull_b = b;
    m_pull(int'(a), int'(b));
    tick();
    pull_a = 1'b0;
    pull_b = 1'b0;
  endtask

  task automatic pulses(input int na, input int nb);
    for (int i = 0; i < na || i < nb; i++)
      pulse(i < na, i < nb);
  endtask

  task automatic do_start();
    start = 1'b1;
    m_start();
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic frame(input bit late_b);
    vsync = 1'b1;
    m_frame(cyc);
    tick();
    if (late_b) begin
      pull_b = 1'b1;
      m_pull(0, 1);
    end
    tick();
    pull_b = 1'b0;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_state(input string tag);
    chk({tag, " u0 loc"}, int'(loc0), m_loc[0]);
    chk({tag, " u0 state"}, int'(gs0), m_st[0]);
    chk({tag, " u1 loc"}, int'(loc1), m_loc[1]);
    chk({tag, " u1 state"}, int'(gs1), m_st[1]);
    chk({tag, " u0 pending"}, q0.size(), 0);
    chk({tag, " u1 pending"}, q1.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; pull_a = 1'b0;
    pull_b = 1'b0; start = 1'b0;
    m_reset();
    tick();
    do_reset();
    chk("reset upd", int'(upd0), 0);
    check_state("reset");

    pulses(0, 5);
    frame(1'b0);
    check_state("idle");

    do_start();
    pulses(1, 3);
    frame(1'b0);
    check_state("net pull");

    do_start();
    pulses(25, 0);
    frame(1'b0);
    check_state("sat 1");
    pulses(25, 0);
    frame(1'b0);
    check_state("sat 2");
    pulses(5, 9);
    frame(1'b0);
    check_state("frozen win");

    do_start();
    pulse(1'b1, 1'b1);
    frame(1'b0);
    check_state("simultaneous");
    frame(1'b1);
    frame(1'b0);
    check_state("late pull");

    do_start();
    pulses(0, 15);
    frame(1'b0);
    check_state("clamp");
    pulses(3, 7);
    do_reset();
    frame(1'b0);
    check_state("reset mid");

    do_start();
    pulses(1, 3);
    frame(1'b0);
    for (int i = 0; i < 8; i++) frame(1'b0);
    check_state("drift");

    for (int it = 0; it < 40; it++) begin
      int r, pa_pct, pb_pct, len;
      r = $urandom_range(0, 99);
      if (r < 4) do_reset();
      else if (r < 16) do_start();
      pa_pct = $urandom_range(0, 70);
      pb_pct = $urandom_range(0, 70);
      len = $urandom_range(0, 30);
      for (int c = 0; c < len; c++)
        pulse($urandom_range(0, 99) < pa_pct, $urandom_range(0, 99) < pb_pct);
      frame($urandom_range(0, 3) == 0);
      check_state("random");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
